// File: rtl/mole_game_pkg.sv
// ---------------------------------------------------------------------------
// mole_game_pkg : shared game encodings, counter width and LFSR step (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package mole_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } game_state_e;

  localparam int         CNT_W      = 4;
  localparam logic [2:0] POS_OFFSET = 3'd2;

  // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8 : free-running 8-bit Fibonacci LFSR, reloads seed on reset (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr8
  import mole_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= seed;
    else     q <= lfsr8_next(q);
  end

endmodule

`default_nettype wire

// File: rtl/mole_game_ctrl.sv
// ---------------------------------------------------------------------------
// mole_game_ctrl : whack-a-mole game FSM, scoring and mole placement (rev 1.0)
// Build option MOLE_WRONG_PENALTY_EN charges a miss for wrong-hole presses.
// ---------------------------------------------------------------------------
`default_nettype none

module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int         MOLE_CYCLES = 1000,
  parameter int         WIN_SCORE   = 10,
  parameter int         MAX_MISS    = 5,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      btn,
  output logic [1:0]       state,
  output logic [2:0]       rowran,
  output logic [2:0]       colran,
  output logic             hit,
  output logic             new_mole,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] miss
);

  localparam int               MC_W     = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;
  localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(MOLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] MISS_CNT = CNT_W'(MAX_MISS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  game_state_e      state_q, state_d;
  logic             start_q, start_in_rst;
  logic [15:0]      btn_q;
  logic [7:0]       lfsr_q;
  logic [MC_W-1:0]  mole_cnt, mole_cnt_d;
  logic [2:0]       rowran_d, colran_d;
  logic             hit_d, new_mole_d;
  logic [CNT_W-1:0] score_d, miss_d, score_inc, miss_inc;

  logic        start_edge, in_play, tc, hit_now, wrong_press, miss_now;
  logic        reach_win, reach_lose, redraw;
  logic [15:0] btn_edge, mole_sel;
  logic [3:0]  mole_idx, lfsr_nx_lo, draw;
  logic [2:0]  place_row, place_col;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // A start level held through reset must not look like a fresh press
  assign start_edge = start & ~start_q & ~start_in_rst;
  assign btn_edge   = btn & ~btn_q;

  assign mole_idx = {rowran[1:0] - POS_OFFSET[1:0], colran[1:0] - POS_OFFSET[1:0]};
  assign mole_sel = 16'd1 << mole_idx;

  assign in_play  = (state_q == ST_PLAY);
  assign tc       = in_play && (mole_cnt == MC_LAST);
  assign hit_now  = in_play && !hit && |(btn_edge & mole_sel);

`ifdef MOLE_WRONG_PENALTY_EN
  assign wrong_press = in_play && |(btn_edge & ~mole_sel) && !hit_now;
`else
  assign wrong_press = 1'b0;
`endif

  assign miss_now   = (tc && !hit && !hit_now) || wrong_press;
  assign score_inc  = (score != CNT_MAX) ? score + CNT_W'(1) : score;
  assign miss_inc   = (miss  != CNT_MAX) ? miss  + CNT_W'(1) : miss;
  assign reach_win  = hit_now  && (score_inc == WIN_CNT);
  assign reach_lose = miss_now && (miss_inc  == MISS_CNT);

  // Placement draws from the current LFSR value, or its successor on a repeat
  assign lfsr_nx_lo = {lfsr_q[2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign redraw     = ((POS_OFFSET + {1'b0, lfsr_q[1:0]}) == rowran) &&
                      ((POS_OFFSET + {1'b0, lfsr_q[3:2]}) == colran);
  assign draw       = redraw ? lfsr_nx_lo : lfsr_q[3:0];
  assign place_row  = POS_OFFSET + {1'b0, draw[1:0]};
  assign place_col  = POS_OFFSET + {1'b0, draw[3:2]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_edge) state_d = ST_PLAY;
      ST_PLAY: begin
        if (reach_win)       state_d = ST_WIN;
        else if (reach_lose) state_d = ST_LOSE;
      end
      ST_WIN, ST_LOSE: if (start_edge) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    score_d    = score;
    miss_d     = miss;
    hit_d      = hit;
    rowran_d   = rowran;
    colran_d   = colran;
    mole_cnt_d = mole_cnt;
    new_mole_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          score_d    = '0;
          miss_d     = '0;
          hit_d      = 1'b0;
          mole_cnt_d = '0;
          rowran_d   = place_row;
          colran_d   = place_col;
          new_mole_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit_now) begin
          hit_d   = 1'b1;
          score_d = score_inc;
        end
        if (miss_now) miss_d = miss_inc;
        if (tc) begin
          mole_cnt_d = '0;
          hit_d      = 1'b0;
          // The game-ending cycle leaves the last mole frozen in place
          if (state_d == ST_PLAY) begin
            rowran_d   = place_row;
            colran_d   = place_col;
            new_mole_d = 1'b1;
          end
        end else begin
          mole_cnt_d = mole_cnt + MC_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score        <= '0;
      miss         <= '0;
      hit          <= 1'b0;
      new_mole     <= 1'b0;
      rowran       <= POS_OFFSET;
      colran       <= POS_OFFSET;
      mole_cnt     <= '0;
      start_q      <= 1'b0;
      btn_q        <= '0;
      start_in_rst <= start;
    end else begin
      score        <= score_d;
      miss         <= miss_d;
      hit          <= hit_d;
      new_mole     <= new_mole_d;
      rowran       <= rowran_d;
      colran       <= colran_d;
      mole_cnt     <= mole_cnt_d;
      start_q      <= start;
      btn_q        <= btn;
      start_in_rst <= 1'b0;
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mole_game_ctrl : directed self-checking bench for mole_game_ctrl (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mole_game_ctrl;

  localparam int         MC   = 1000;
  localparam logic [7:0] SEED = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] btn = '0;
  logic [1:0]  state;
  logic [2:0]  rowran, colran;
  logic        hit, new_mole;
  logic [3:0]  score, miss;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int e0, e1, idx;

  logic [7:0] m_lfsr;
  logic [2:0] exp_r = 3'd2;
  logic [2:0] exp_c = 3'd2;
  logic [3:0] exp_miss;

  mole_game_ctrl #(
    .MOLE_CYCLES (MC),
    .WIN_SCORE   (2),
    .MAX_MISS    (5),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .btn      (btn),
    .state    (state),
    .rowran   (rowran),
    .colran   (colran),
    .hit      (hit),
    .new_mole (new_mole),
    .score    (score),
    .miss     (miss)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, reloaded on reset, stepping every cycle
  always @(posedge clk)
    m_lfsr <= rst ? SEED : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Expected next mole from the reference LFSR value sampled at the placing edge
  task automatic predict();
    logic [7:0] l;
    logic [2:0] r, c;
    l = m_lfsr;
    r = 3'd2 + {1'b0, l[1:0]};
    c = 3'd2 + {1'b0, l[3:2]};
    if (r == exp_r && c == exp_c) begin
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      r = 3'd2 + {1'b0, l[1:0]};
      c = 3'd2 + {1'b0, l[3:2]};
    end
    exp_r = r;
    exp_c = c;
  endtask

  function automatic int hole(input logic [2:0] r, input logic [2:0] c);
    return (int'(r) - 2) * 4 + (int'(c) - 2);
  endfunction

  initial begin
`ifdef MOLE_WRONG_PENALTY_EN
    exp_miss = 4'd1;
`else
    exp_miss = 4'd0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_score", 16'(score), 16'd0);
    chk("rst_miss", 16'(miss), 16'd0);
    chk("rst_hit", 16'(hit), 16'd0);
    chk("rst_new_mole", 16'(new_mole), 16'd0);
    chk("rst_row", 16'(rowran), 16'd2);
    chk("rst_col", 16'(colran), 16'd2);

    // First game: start, hit mid-mole, repeat press, wrong press, start in PLAY
    predict();
    start = 1'b1;
    tick();
    e0 = cyc;
    chk("start_state", 16'(state), 16'd1);
    chk("start_new_mole", 16'(new_mole), 16'd1);
    chk("start_score", 16'(score), 16'd0);
    chk("start_miss", 16'(miss), 16'd0);
    chk("start_row", 16'(rowran), 16'(exp_r));
    chk("start_col", 16'(colran), 16'(exp_c));
    chk("start_row_range", 16'(rowran >= 3'd2 && rowran <= 3'd5), 16'd1);
    start = 1'b0;
    tick();
    chk("new_mole_pulse_end", 16'(new_mole), 16'd0);

    idx = hole(exp_r, exp_c);
    btn[idx] = 1'b1;
    tick();
    chk("hit_flag", 16'(hit), 16'd1);
    chk("hit_score", 16'(score), 16'd1);
    btn = '0;
    tick();
    btn[idx] = 1'b1;
    tick();
    chk("rehit_score", 16'(score), 16'd1);
    btn = '0;
    tick();
    btn[(idx + 1) % 16] = 1'b1;
    tick();
    btn = '0;
    chk("wrong_press_miss", 16'(miss), 16'(exp_miss));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("start_in_play", 16'(state), 16'd1);

    // Terminal count with the mole already hit: new mole, no miss
    run_to(e0 + MC - 1);
    predict();
    tick();
    chk("tc1_new_mole", 16'(new_mole), 16'd1);
    chk("tc1_hit_clr", 16'(hit), 16'd0);
    chk("tc1_miss", 16'(miss), 16'(exp_miss));
    chk("tc1_row", 16'(rowran), 16'(exp_r));
    chk("tc1_col", 16'(colran), 16'(exp_c));

    // Hit landing on the terminal-count edge reaches WIN_SCORE=2
    run_to(e0 + 2 * MC - 1);
    idx = hole(exp_r, exp_c);
    btn[idx] = 1'b1;
    tick();
    btn = '0;
    chk("tc2_score", 16'(score), 16'd2);
    chk("tc2_miss", 16'(miss), 16'(exp_miss));
    chk("tc2_hit", 16'(hit), 16'd0);
    chk("win_state", 16'(state), 16'd2);
    chk("win_new_mole", 16'(new_mole), 16'd0);
    chk("win_row_frozen", 16'(rowran), 16'(exp_r));
    tick();
    btn[idx] = 1'b1;
    tick();
    btn = '0;
    chk("win_press_ignored", 16'(score), 16'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("win_to_idle", 16'(state), 16'd0);
    tick();
    btn[3] = 1'b1;
    tick();
    btn = '0;
    tick();
    chk("idle_press_ignored", 16'(score), 16'd2);

    // Second game: never press, lose after MAX_MISS moles
    predict();
    start = 1'b1;
    tick();
    start = 1'b0;
    e1 = cyc;
    chk("restart_state", 16'(state), 16'd1);
    chk("restart_score", 16'(score), 16'd0);
    chk("restart_miss", 16'(miss), 16'd0);
    chk("restart_row", 16'(rowran), 16'(exp_r));
    for (int k = 1; k <= 5; k++) begin
      run_to(e1 + k * MC - 1);
      if (k < 5) predict();
      tick();
      chk($sformatf("miss_%0d", k), 16'(miss), 16'(k));
      if (k < 5) begin
        chk($sformatf("mole_%0d_col", k), 16'(colran), 16'(exp_c));
        chk($sformatf("mole_%0d_pulse", k), 16'(new_mole), 16'd1);
      end else begin
        chk("lose_state", 16'(state), 16'd3);
        chk("lose_new_mole", 16'(new_mole), 16'd0);
      end
    end
    run_to(cyc + MC + 5);
    chk("lose_miss_frozen", 16'(miss), 16'd5);
    chk("lose_state_held", 16'(state), 16'd3);
    chk("lose_row_frozen", 16'(rowran), 16'(exp_r));
    chk("lose_col_frozen", 16'(colran), 16'(exp_c));
    chk("lose_no_pulse", 16'(new_mole), 16'd0);

    // Reset mid-PLAY with start held high throughout
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lose_to_idle", 16'(state), 16'd0);
    tick();
    predict();
    start = 1'b1;
    tick();
    chk("game3_state", 16'(state), 16'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_r = 3'd2;
    exp_c = 3'd2;
    tick();
    chk("midplay_rst_idle", 16'(state), 16'd0);
    chk("midplay_rst_row", 16'(rowran), 16'd2);
    repeat (3) tick();
    chk("held_start_no_edge", 16'(state), 16'd0);
    start = 1'b0;
    tick();
    predict();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_start", 16'(state), 16'd1);
    chk("post_rst_row", 16'(rowran), 16'(exp_r));
    chk("post_rst_col", 16'(colran), 16'(exp_c));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
